fifo_ctrl: RTL and testbench
============================

# fifo_ctrl

Control unit that turns a register-file storage array into a synchronous first-in-first-out buffer. It accepts push and pop requests and keeps the write and read pointers. It generates the gated write enable and the write and read addresses that drive the register file's write and read ports. It also reports occupancy and status flags to the producer and consumer. One instance is paired with one register file of matching address width, and together they form the codebase's standard FIFO.

## Interface
Parameters:
- W, 2: address bits; FIFO depth is 2^W words.
- AF_LVL, 2^W-1: almost_full asserts when count >= AF_LVL.
- AE_LVL, 1: almost_empty asserts when count <= AE_LVL.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wr  in  1  push request from the producer; sampled each cycle.
- rd  in  1  pop request from the consumer; sampled each cycle.
- wr_en  out  1  gated write enable to the register file (combinational).
- w_addr  out  W  write address to the register file; equals the write pointer.
- r_addr  out  W  read address to the register file; equals the read pointer.
- full  out  1  registered; FIFO holds 2^W words.
- empty  out  1  registered; FIFO holds 0 words.
- count  out  W+1  registered occupancy, 0..2^W.
- almost_full  out  1  registered, compares count to AF_LVL.
- almost_empty  out  1  registered, compares count to AE_LVL.
- overflow  out  1  registered one-cycle pulse for a rejected push.
- underflow  out  1  registered one-cycle pulse for a rejected pop.

## Operation
- State consists of w_ptr[W-1:0], r_ptr[W-1:0], count[W:0], full, empty, almost_full, almost_empty, overflow and underflow.
- Both pointers wrap modulo 2^W, so the pointer after 2^W-1 is 0.
- A push is accepted when wr & (~full | rd). If empty & rd & wr, the push is accepted and the pop is not.
- A pop is accepted when rd & ~empty.
- wr_en = push accepted. The write occurs at w_addr on the same edge.
- Each edge applies the accepted operations as follows:
  - Push only: w_ptr+1, count+1.
  - Pop only: r_ptr+1, count-1.
  - Both: both pointers +1, count unchanged, full and empty unchanged.
  - Neither: no change.
- When the FIFO is full and rd & wr, the register file is written at w_addr == r_addr. The consumer sees the old word combinationally in that cycle, and the new word becomes the tail.
- full, empty, almost_full and almost_empty are recomputed from the next count value and registered, so they are never combinational.
- overflow is set for one cycle after a cycle with wr & full & ~rd.
- underflow is set for one cycle after a cycle with rd & empty, whether or not wr is also high.
- Rejected requests do not change pointers or count.

## Timing
- On reset: w_ptr=0, r_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0. During reset, wr_en=0 regardless of wr.
- Reset asserted mid-operation discards all contents on that edge. Requests in the reset cycle are ignored, and no error pulses are generated for them.
- Read latency is zero. The head word is valid on the register file's read data in any cycle where empty=0, because r_addr comes from a register and the read port is combinational.
- Write latency is one edge. A word pushed at edge N is readable from the cycle after edge N, and empty falls at edge N.
- The flags reflect all operations accepted up to and including the previous edge.
- Requests need no handshake: the caller holds wr or rd for exactly the cycles it intends to act.

## Test plan
Use W=2 (depth 4), AF_LVL=3 and AE_LVL=1 for all scenarios.
- Reset, then push 0xA1, 0xB2, 0xC3, 0xD4 on consecutive cycles:
  - full rises after the 4th edge, and count is 1, 2, 3, 4.
  - almost_full rises after the 3rd edge, and empty falls after the 1st edge.
  - w_addr sequence is 0, 1, 2, 3, then 0.
- From full, pulse wr alone → overflow=1 for exactly one cycle, wr_en=0, and count stays 4. Then pop 4 times → heads read 0xA1, 0xB2, 0xC3, 0xD4, and empty=1 after the 4th pop.
- From empty, assert rd → underflow pulses for one cycle and r_addr stays unchanged. Then assert rd&wr with data 0x55 → only the push is accepted, count=1, and the head reads 0x55 next cycle.
- From full, assert rd&wr for 3 cycles → each cycle returns the old head, full stays 1, count stays 4, and both pointers advance by 3 with wrap.
- Wrap-around: push and pop 10 words interleaved (push, push, pop, ...) → data comes out in order and count never exceeds 2.
- With count=3, assert reset together with wr → next cycle count=0, empty=1, both pointers 0, wr_en was 0, and overflow is 0.

Source files
------------

// File: rtl/fifo_ctrl_if.sv
// Producer/consumer-side bundle between fifo_ctrl and its users.
// The master drives the requests; the slave (fifo_ctrl) drives the addresses and status.
interface fifo_ctrl_if #(
   parameter int unsigned W = 2
);
   logic         wr;
   logic         rd;
   logic         wr_en;
   logic [W-1:0] w_addr;
   logic [W-1:0] r_addr;
   logic         full;
   logic         empty;
   logic [W:0]   count;
   logic         almost_full;
   logic         almost_empty;
   logic         overflow;
   logic         underflow;

   modport master (
      output wr, rd,
      input  wr_en, w_addr, r_addr, full, empty, count,
             almost_full, almost_empty, overflow, underflow
   );

   modport slave (
      input  wr, rd,
      output wr_en, w_addr, r_addr, full, empty, count,
             almost_full, almost_empty, overflow, underflow
   );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer/occupancy controller that turns a register file into a synchronous FIFO.
// Status flags are registered from the next occupancy; wr_en is the only combinational output.
module fifo_ctrl #(
   parameter int unsigned W      = 2,
   parameter int unsigned AF_LVL = (2 ** W) - 1,
   parameter int unsigned AE_LVL = 1
) (
   input  logic         clk,
   input  logic         reset,
   fifo_ctrl_if.slave   bus
);
   localparam int unsigned DEPTH = 2 ** W;
   localparam int unsigned CW    = W + 1;

   logic [W-1:0]  w_ptr;
   logic [W-1:0]  r_ptr;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_nxt;
   logic          full_q;
   logic          empty_q;
   logic          almost_full_q;
   logic          almost_empty_q;
   logic          overflow_q;
   logic          underflow_q;
   logic          push;
   logic          pop;

   // Acceptance: a push into a full FIFO is allowed only when a pop frees the slot
   always_comb begin
      push      = 1'b0;
      pop       = 1'b0;
      count_nxt = count_q;
      push      = bus.wr & (~full_q | bus.rd) & ~reset;
      pop       = bus.rd & ~empty_q & ~reset;
      count_nxt = count_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         w_ptr          <= '0;
         r_ptr          <= '0;
         count_q        <= '0;
         full_q         <= 1'b0;
         empty_q        <= 1'b1;
         almost_full_q  <= 1'b0;
         almost_empty_q <= 1'b1;
         overflow_q     <= 1'b0;
         underflow_q    <= 1'b0;
      end else begin
         if (push) w_ptr <= w_ptr + W'(1);
         if (pop)  r_ptr <= r_ptr + W'(1);
         count_q        <= count_nxt;
         full_q         <= (count_nxt == CW'(DEPTH));
         empty_q        <= (count_nxt == '0);
         almost_full_q  <= (count_nxt >= CW'(AF_LVL));
         almost_empty_q <= (count_nxt <= CW'(AE_LVL));
         // Error pulses flag the request, not the acceptance outcome
         overflow_q     <= bus.wr & full_q & ~bus.rd;
         underflow_q    <= bus.rd & empty_q;
      end
   end

   assign bus.wr_en        = push;
   assign bus.w_addr       = w_ptr;
   assign bus.r_addr       = r_ptr;
   assign bus.count        = count_q;
   assign bus.full         = full_q;
   assign bus.empty        = empty_q;
   assign bus.almost_full  = almost_full_q;
   assign bus.almost_empty = almost_empty_q;
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl paired with an 8-bit register-file model; a queue scoreboard
// holds expected head words and a negedge monitor compares them on every accepted pop.
module tb_fifo_ctrl;
   logic       clk;
   logic       reset;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic [7:0] mem [4];
   logic       wr_en_seen;
   logic [7:0] exp_q [$];
   int         errors;
   int         checks;
   int         exp_cnt;

   fifo_ctrl_if #(.W(2)) bus ();

   fifo_ctrl #(.W(2), .AF_LVL(3), .AE_LVL(1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Register file: synchronous write, combinational read
   always @(posedge clk) if (bus.wr_en) mem[bus.w_addr] <= wdata;
   assign rdata = mem[bus.r_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // Monitor: any cycle the consumer pops a non-empty FIFO, the head must match the scoreboard
   always @(negedge clk) begin
      if (!reset && bus.rd && !bus.empty) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL head: got %0h expected nothing (scoreboard empty) at %0t", rdata, $time);
         end else begin
            check("head", 32'(rdata), 32'(exp_q.pop_front()));
         end
      end
   end

   // One request cycle; acc marks a push the bench expects to be accepted
   task automatic cyc(input logic w, input logic r, input logic [7:0] d, input logic acc);
      bus.wr = w;
      bus.rd = r;
      wdata  = d;
      if (acc) exp_q.push_back(d);
      @(negedge clk);
      wr_en_seen = bus.wr_en;
      @(posedge clk);
      #1;
      bus.wr = 1'b0;
      bus.rd = 1'b0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset  = 1'b1;
      bus.wr = 1'b0;
      bus.rd = 1'b0;
      wdata  = 8'h00;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;

      check("rst_count", 32'(bus.count), 0);
      check("rst_empty", 32'(bus.empty), 1);
      check("rst_full", 32'(bus.full), 0);
      check("rst_ae", 32'(bus.almost_empty), 1);
      check("rst_af", 32'(bus.almost_full), 0);
      check("rst_ovf", 32'(bus.overflow), 0);
      check("rst_unf", 32'(bus.underflow), 0);
      check("rst_waddr", 32'(bus.w_addr), 0);
      check("rst_raddr", 32'(bus.r_addr), 0);

      // Fill: A1 B2 C3 D4
      check("waddr0", 32'(bus.w_addr), 0);
      cyc(1, 0, 8'hA1, 1);
      check("wr_en1", 32'(wr_en_seen), 1);
      check("cnt1", 32'(bus.count), 1);
      check("empty1", 32'(bus.empty), 0);
      check("ae1", 32'(bus.almost_empty), 1);
      check("waddr1", 32'(bus.w_addr), 1);
      cyc(1, 0, 8'hB2, 1);
      check("cnt2", 32'(bus.count), 2);
      check("ae2", 32'(bus.almost_empty), 0);
      check("af2", 32'(bus.almost_full), 0);
      check("waddr2", 32'(bus.w_addr), 2);
      cyc(1, 0, 8'hC3, 1);
      check("cnt3", 32'(bus.count), 3);
      check("af3", 32'(bus.almost_full), 1);
      check("full3", 32'(bus.full), 0);
      check("waddr3", 32'(bus.w_addr), 3);
      cyc(1, 0, 8'hD4, 1);
      check("cnt4", 32'(bus.count), 4);
      check("full4", 32'(bus.full), 1);
      check("waddr4", 32'(bus.w_addr), 0);

      // Push into full FIFO is rejected with a one-cycle overflow pulse
      cyc(1, 0, 8'hEE, 0);
      check("ovf_wr_en", 32'(wr_en_seen), 0);
      check("ovf_pulse", 32'(bus.overflow), 1);
      check("ovf_cnt", 32'(bus.count), 4);
      cyc(0, 0, 8'h00, 0);
      check("ovf_clear", 32'(bus.overflow), 0);

      // Drain: heads A1 B2 C3 D4
      for (int i = 0; i < 4; i++) cyc(0, 1, 8'h00, 0);
      check("drain_empty", 32'(bus.empty), 1);
      check("drain_cnt", 32'(bus.count), 0);
      check("drain_raddr", 32'(bus.r_addr), 0);

      // Pop from empty: underflow pulse, pointer unchanged
      cyc(0, 1, 8'h00, 0);
      check("unf_pulse", 32'(bus.underflow), 1);
      check("unf_raddr", 32'(bus.r_addr), 0);
      cyc(0, 0, 8'h00, 0);
      check("unf_clear", 32'(bus.underflow), 0);

      // rd&wr while empty: only the push is taken
      cyc(1, 1, 8'h55, 1);
      check("ew_wr_en", 32'(wr_en_seen), 1);
      check("ew_cnt", 32'(bus.count), 1);
      check("ew_unf", 32'(bus.underflow), 1);
      check("ew_raddr", 32'(bus.r_addr), 0);
      cyc(0, 1, 8'h00, 0);
      check("ew_pop_cnt", 32'(bus.count), 0);

      // Refill to full from pointers at 1, then rd&wr three times
      for (int i = 0; i < 4; i++) cyc(1, 0, 8'(8'h10 + i), 1);
      check("refill_full", 32'(bus.full), 1);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 1, 8'(8'h20 + i), 1);
         check("rw_full", 32'(bus.full), 1);
         check("rw_cnt", 32'(bus.count), 4);
         check("rw_wr_en", 32'(wr_en_seen), 1);
      end
      check("rw_waddr", 32'(bus.w_addr), 0);
      check("rw_raddr", 32'(bus.r_addr), 0);
      for (int i = 0; i < 4; i++) cyc(0, 1, 8'h00, 0);
      check("rw_drain_empty", 32'(bus.empty), 1);

      // Interleaved push/pop wrapping the pointers several times
      exp_cnt = 0;
      cyc(1, 0, 8'h30, 1);
      exp_cnt = 1;
      check("il_cnt", 32'(bus.count), 32'(exp_cnt));
      for (int i = 1; i < 10; i++) begin
         cyc(1, 0, 8'(8'h30 + i), 1);
         exp_cnt++;
         check("il_cnt", 32'(bus.count), 32'(exp_cnt));
         cyc(0, 1, 8'h00, 0);
         exp_cnt--;
         check("il_cnt", 32'(bus.count), 32'(exp_cnt));
      end
      cyc(0, 1, 8'h00, 0);
      check("il_empty", 32'(bus.empty), 1);

      // Reset with count=3 and a concurrent push request
      for (int i = 0; i < 3; i++) cyc(1, 0, 8'(8'h40 + i), 1);
      check("pre_rst_cnt", 32'(bus.count), 3);
      reset = 1'b1;
      cyc(1, 0, 8'h99, 0);
      reset = 1'b0;
      exp_q.delete();
      check("mid_rst_wr_en", 32'(wr_en_seen), 0);
      check("mid_rst_cnt", 32'(bus.count), 0);
      check("mid_rst_empty", 32'(bus.empty), 1);
      check("mid_rst_waddr", 32'(bus.w_addr), 0);
      check("mid_rst_raddr", 32'(bus.r_addr), 0);
      check("mid_rst_ovf", 32'(bus.overflow), 0);
      check("mid_rst_ae", 32'(bus.almost_empty), 1);

      check("sb_drained", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
